// File: rtl/mole_spawner_if.sv
// Game-event bus between the whack-a-mole spawner and its neighbours.
// The slave side is the spawner; the master side drives enable/tick/rnd/btn.
interface mole_spawner_if #(
  parameter int unsigned NUM_HOLES = 4
) ();
  logic                 enable;
  logic                 tick;
  logic [7:0]           rnd;
  logic [NUM_HOLES-1:0] btn;
  logic [NUM_HOLES-1:0] mole;
  logic                 hit;
  logic                 miss;

  modport master (
    output enable, tick, rnd, btn,
    input  mole, hit, miss
  );

  modport slave (
    input  enable, tick, rnd, btn,
    output mole, hit, miss
  );
endinterface

// File: rtl/mole_spawner.sv
// Turns PRNG bytes into mole spawns and judges presses as hit/miss.
// Optional MOLE_SPEEDUP_EN: each hit shortens later mole-up times (level 0..7).
module mole_spawner #(
  parameter int unsigned NUM_HOLES = 4,
  parameter int unsigned UP_BASE   = 8,
  parameter int unsigned UP_STEP   = 2,
  parameter int unsigned GAP_TICKS = 4,
  parameter int unsigned MAX_TRIES = 8
) (
  input logic           clk,
  input logic           rst_n,
  mole_spawner_if.slave bus
);
  localparam int unsigned TriesW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [NUM_HOLES-1:0] HoleLsb = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StPick, StShow, StGap} state_e;

  state_e               r_state, w_state_d;
  logic [11:0]          r_cnt, w_cnt_d;
  logic [TriesW-1:0]    r_tries, w_tries_d;
  logic [2:0]           r_prev, w_prev_d;
  logic                 r_prev_valid, w_prev_valid_d;
  logic [NUM_HOLES-1:0] r_mole, w_mole_d;
  logic                 r_hit, w_hit_d;
  logic                 r_miss, w_miss_d;

  logic [2:0]           w_cand, w_wrap, w_idx;
  logic                 w_accept, w_take;
  logic [NUM_HOLES-1:0] w_idx_oh, w_prev_oh;
  logic [11:0]          w_up_full, w_load;
  logic                 w_press_ok, w_press_any, w_expire;
  logic                 w_unused_rnd3;

  assign w_unused_rnd3 = bus.rnd[3];
  assign w_cand    = bus.rnd[2:0];
  assign w_accept  = ({29'd0, w_cand} < NUM_HOLES) && (!r_prev_valid || (w_cand != r_prev));
  assign w_wrap    = ({29'd0, r_prev} == NUM_HOLES - 1) ? 3'd0 : r_prev + 3'd1;
  // After MAX_TRIES rejects fall back to the hole after the previous one.
  assign w_take    = w_accept || (r_tries == TriesW'(MAX_TRIES - 1));
  assign w_idx     = w_accept ? w_cand : w_wrap;
  assign w_idx_oh  = HoleLsb << w_idx;
  assign w_prev_oh = HoleLsb << r_prev;
  assign w_up_full = 12'(UP_BASE) + 12'(bus.rnd[7:4]) * 12'(UP_STEP);

  assign w_press_ok  = |(bus.btn & w_prev_oh);
  assign w_press_any = |bus.btn;
  assign w_expire    = bus.tick && (r_cnt <= 12'd1);

`ifdef MOLE_SPEEDUP_EN
  logic [2:0]  r_level, w_level_d;
  logic [11:0] w_up_dec;

  assign w_up_dec = 12'(r_level) * 12'(UP_STEP);
  assign w_load   = (w_up_full > w_up_dec) ? w_up_full - w_up_dec : 12'd1;

  always_comb begin
    w_level_d = r_level;
    if (!bus.enable) begin
      w_level_d = 3'd0;
    end else if (w_hit_d && (r_level != 3'd7)) begin
      w_level_d = r_level + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 3'd0;
    end else begin
      r_level <= w_level_d;
    end
  end
`else
  assign w_load = w_up_full;
`endif

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_tries_d      = r_tries;
    w_prev_d       = r_prev;
    w_prev_valid_d = r_prev_valid;
    w_mole_d       = r_mole;
    w_hit_d        = 1'b0;
    w_miss_d       = 1'b0;
    if (!bus.enable) begin
      w_state_d = StIdle;
      w_mole_d  = '0;
      w_tries_d = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_mole_d  = '0;
          w_state_d = StPick;
        end
        StPick: begin
          if (w_take) begin
            w_prev_d       = w_idx;
            w_prev_valid_d = 1'b1;
            w_tries_d      = '0;
            w_cnt_d        = w_load;
            w_mole_d       = w_idx_oh;
            w_state_d      = StShow;
          end else begin
            w_tries_d = r_tries + 1'b1;
          end
        end
        StShow: begin
          // A correct bit wins over wrong bits and over the final tick.
          if (w_press_any || w_expire) begin
            w_hit_d   = w_press_ok;
            w_miss_d  = !w_press_ok;
            w_mole_d  = '0;
            w_cnt_d   = 12'(GAP_TICKS);
            w_state_d = StGap;
          end else if (bus.tick) begin
            w_cnt_d = r_cnt - 12'd1;
          end
        end
        StGap: begin
          if (bus.tick) begin
            if (r_cnt <= 12'd1) begin
              w_cnt_d   = '0;
              w_state_d = StPick;
            end else begin
              w_cnt_d = r_cnt - 12'd1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_tries      <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_mole       <= '0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_tries      <= w_tries_d;
      r_prev       <= w_prev_d;
      r_prev_valid <= w_prev_valid_d;
      r_mole       <= w_mole_d;
      r_hit        <= w_hit_d;
      r_miss       <= w_miss_d;
    end
  end

  assign bus.mole = r_mole;
  assign bus.hit  = r_hit;
  assign bus.miss = r_miss;
endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Consumes the 8-bit LFSR byte and turns it into game events for the whack-a-mole core.
- Picks which hole lights, and how long the mole stays up.
- Judges button presses as hit or miss.
- Sits between the PRNG and the score/display logic; its mole vector drives the hole LEDs, and its hit/miss pulses feed the scorer.

Parameters:
- NUM_HOLES, 4, number of holes; legal range 2..8.
- UP_BASE, 8, minimum mole-up time in ticks.
- UP_STEP, 2, ticks added per unit of rnd[7:4].
- GAP_TICKS, 4, ticks with no mole between spawns.
- MAX_TRIES, 8, rejected samples allowed before the deterministic fallback.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  game running; level-sensitive.
- tick  input  1  one-cycle timebase strobe (e.g. 1 ms); all durations count ticks.
- rnd  input  8  current PRNG state; changes every clk.
- btn  input  NUM_HOLES  debounced, synchronised, one-cycle press pulses, one bit per hole.
- mole  output  NUM_HOLES  one-hot lit hole; all zero when no mole is up.
- hit  output  1  one-cycle pulse: correct press.
- miss  output  1  one-cycle pulse: wrong press or timeout.

Behaviour:
- Reset (async, rst_n=0):
  - mole=0, hit=0, miss=0.
  - State IDLE, counter=0, tries=0, prev_valid=0.
- States: IDLE, PICK, SHOW, GAP. A 12-bit down-counter serves SHOW and GAP. Configuration is illegal unless UP_BASE+15*UP_STEP < 4096.
- IDLE:
  - mole=0.
  - enable=1 -> PICK next cycle.
- PICK (one candidate per clk):
  - cand=rnd[2:0].
  - Accept if cand<NUM_HOLES and (prev_valid=0 or cand!=prev).
  - On reject, tries increments.
  - On the clk where tries==MAX_TRIES-1 and the candidate is rejected, use idx=(prev+1) mod NUM_HOLES instead. This bounds PICK at MAX_TRIES cycles.
  - On accept/fallback:
    - Latch idx into prev; set prev_valid=1; clear tries.
    - Load counter = UP_BASE + rnd[7:4]*UP_STEP, using the same-cycle rnd.
    - Go to SHOW.
  - mole becomes onehot(idx) on the next clk edge (1-cycle latency from accept).
- SHOW:
  - mole=onehot(idx).
  - Counter decrements on each tick.
  - btn[idx]=1 -> hit=1 for one cycle; GAP.
  - btn nonzero with btn[idx]=0 -> miss=1; GAP.
  - tick with counter==1 (reaching 0) and no press -> miss=1; GAP.
  - Simultaneous correct press and final tick -> hit only.
  - Simultaneous correct and wrong bits in btn -> hit (correct bit wins).
- GAP:
  - mole=0 on entry; counter loaded with GAP_TICKS.
  - Decrement on tick; reaching 0 -> PICK.
  - btn ignored.
- enable=0 in any state:
  - IDLE on next clk; mole=0.
  - No hit/miss pulse; tries cleared; prev/prev_valid retained.
- hit and miss are registered, never both high, and never high for more than one cycle.
- tick while in PICK or IDLE has no effect.

Optional Feature:
- Macro MOLE_SPEEDUP_EN.
- Defined:
  - A 3-bit level register is cleared on reset and whenever enable=0.
  - level increments on each hit and saturates at 7.
  - SHOW load = max(1, UP_BASE + rnd[7:4]*UP_STEP - level*UP_STEP), computed without wrap.
- Not defined:
  - No level register.
  - Load exactly as in Behaviour.
  - Port list is identical in both builds.

Test Plan (NUM_HOLES=4, UP_BASE=8, UP_STEP=2, GAP_TICKS=4, tick=1 every cycle unless stated):
1. Reset check: assert rst_n=0 mid-SHOW -> mole=4'b0000, hit=0, miss=0 immediately (async). Release with enable=0 -> remains IDLE, mole=0 for 20 cycles.
2. Spawn and timeout: enable=1, rnd=8'h32 in PICK -> mole=4'b0100 next cycle, held 14 ticks. Then miss=1 for exactly 1 cycle, mole=0 for 4 ticks, then PICK.
3. Hit and wrong press:
   - Hit: in SHOW with idx=2, btn=4'b0100 -> hit=1 one cycle, mole=0 next cycle.
   - Wrong press: btn=4'b0001 -> miss=1 one cycle, mole=0 next cycle.
4. Rejection and fallback:
   - Repeat avoidance: prev=2, rnd=8'h02 -> rejected.
   - Fallback: hold rnd=8'h06 for 8 cycles -> fallback idx=3, mole=4'b1000.
   - Repeat rejection: prev=3, rnd=8'h03 then 8'h01 -> mole=4'b0010 after the second sample.
5. Simultaneous events:
   - btn=4'b0100 on the tick that would expire idx=2 -> hit=1, miss=0.
   - enable=0 on the same cycle as a correct press -> no pulse, IDLE.
6. Speedup (MOLE_SPEEDUP_EN): rnd[7:4]=0 on every spawn, 3 consecutive hits -> SHOW lengths 8, 6, 4, 2. After 7 hits the load clamps at 1. Toggling enable low resets the length to 8.
